pmp_seq_checker: RTL and testbench

//  Area-lean PMP checker. Shares one pmp_entry match datapath across NR_ENTRIES configured regions.

---
 rtl/pmp_seq_pkg.sv | 75 +++++++
 rtl/pmp_entry.sv | 51 +++++
 rtl/pmp_seq_checker.sv | 187 ++++++++++++++++++
 tb/tb_pmp_seq_checker.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmp_seq_pkg.sv
// Package: pmp_seq_pkg
// Shared types for the sequential PMP checker: privilege/access encodings,
// the pmpcfg layout, the checker FSM states, the response record, the
// last-hit cache tag, and the allow/deny decision function.
package pmp_seq_pkg;

  // Minimal core configuration. A non-zero NrPMPEntries narrows the scan to
  // the entries the core actually implements; zero means "use NR_ENTRIES".
  typedef struct packed {
    logic [7:0] NrPMPEntries;
  } cva6_cfg_t;

  localparam cva6_cfg_t CVA6_CFG_EMPTY = '0;

  // Access bits {x, w, r}
  typedef logic [2:0] pmp_access_t;
  localparam pmp_access_t ACCESS_NONE  = 3'b000;
  localparam pmp_access_t ACCESS_READ  = 3'b001;
  localparam pmp_access_t ACCESS_WRITE = 3'b010;
  localparam pmp_access_t ACCESS_EXEC  = 3'b100;

  typedef logic [1:0] priv_lvl_t;
  localparam priv_lvl_t PRIV_LVL_U = 2'b00;
  localparam priv_lvl_t PRIV_LVL_S = 2'b01;
  localparam priv_lvl_t PRIV_LVL_M = 2'b11;

  typedef enum logic [1:0] {
    PMP_OFF   = 2'b00,
    PMP_TOR   = 2'b01,
    PMP_NA4   = 2'b10,
    PMP_NAPOT = 2'b11
  } pmp_addr_mode_t;

  typedef struct packed {
    logic           locked;
    logic [1:0]     reserved;
    pmp_addr_mode_t addr_mode;
    pmp_access_t    access;
  } pmpcfg_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } state_e;

  // Widths sized for the largest supported build (64 entries, PLEN 64).
  localparam int unsigned IDX_MAX_W  = 6;
  localparam int unsigned TAG_ADDR_W = 62;

  typedef struct packed {
    logic                 allow;
    logic                 hit;
    logic [IDX_MAX_W-1:0] idx;
  } pmp_seq_rsp_t;

  typedef struct packed {
    logic [TAG_ADDR_W-1:0] addr;
    pmp_access_t           access;
    priv_lvl_t             priv;
  } pmp_seq_tag_t;

  function automatic logic pmp_allow(input pmpcfg_t cfg, input pmp_access_t access,
                                     input priv_lvl_t priv, input logic hit);
    logic allow;
    if (hit) begin
      if ((priv == PRIV_LVL_M) && !cfg.locked) allow = 1'b1;
      else                                     allow = ((cfg.access & access) == access);
    end else begin
      allow = (priv == PRIV_LVL_M);
    end
    return allow;
  endfunction

endpackage

// File: rtl/pmp_entry.sv
// Module: pmp_entry
// Single PMP region address matcher (OFF / TOR / NA4 / NAPOT).
// Ports:
//   addr_i            physical byte address
//   conf_addr_i       pmpaddr of this entry (word address, addr >> 2)
//   conf_addr_prev_i  pmpaddr of the previous entry (TOR lower bound)
//   conf_addr_mode_i  address matching mode
//   match_o           1 when addr_i falls inside the region
module pmp_entry
  import pmp_seq_pkg::*;
#(
  parameter int unsigned PLEN    = 56,
  parameter int unsigned PMP_LEN = 54
) (
  input  logic [PLEN-1:0]    addr_i,
  input  logic [PMP_LEN-1:0] conf_addr_i,
  input  logic [PMP_LEN-1:0] conf_addr_prev_i,
  input  pmp_addr_mode_t     conf_addr_mode_i,
  output logic               match_o
);

  localparam int unsigned WordW = PLEN - 2;

  logic [WordW-1:0] word;
  logic [WordW-1:0] base_w;
  logic [WordW-1:0] prev_w;
  logic [WordW-1:0] napot_mask;
  logic             unused_byte_bits;

  // All region bounds are 4-byte aligned, so comparing word addresses is
  // equivalent to comparing byte addresses.
  assign word             = addr_i[PLEN-1:2];
  assign base_w           = WordW'(conf_addr_i);
  assign prev_w           = WordW'(conf_addr_prev_i);
  assign unused_byte_bits = ^addr_i[1:0];

  // x ^ (x + 1) sets exactly the trailing-ones run plus the first zero,
  // i.e. the don't-care bits of a NAPOT region.
  assign napot_mask = ~(base_w ^ (base_w + 1'b1));

  always_comb begin
    match_o = 1'b0;
    case (conf_addr_mode_i)
      PMP_TOR:   match_o = (word >= prev_w) && (word < base_w);
      PMP_NA4:   match_o = (word == base_w);
      PMP_NAPOT: match_o = ((word & napot_mask) == (base_w & napot_mask));
      default:   match_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pmp_seq_checker.sv
// Module: pmp_seq_checker
// Area-lean PMP checker: one pmp_entry matcher is time-shared across the
// entries, scanned in priority order (one per cycle) until the first match.
// Optional feature macro: PMP_SEQ_LAST_HIT_EN (one-entry last-result cache).
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   req_valid_i/ready_o    request handshake (ready only in IDLE)
//   addr_i, access_i,
//   priv_lvl_i             request attributes, latched on accept
//   conf_addr_i, conf_i    live pmpaddr / pmpcfg arrays
//   cfg_update_i           pulse on any PMP CSR write
//   rsp_valid_o/ready_i    response handshake
//   allow_o, hit_o,
//   match_idx_o            decision, match flag, first matching entry
module pmp_seq_checker
  import pmp_seq_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg    = CVA6_CFG_EMPTY,
  parameter int unsigned PLEN       = 56,
  parameter int unsigned PMP_LEN    = 54,
  parameter int unsigned NR_ENTRIES = 16,
  localparam int unsigned IdxW      = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [PLEN-1:0]                   addr_i,
  input  pmp_access_t                       access_i,
  input  priv_lvl_t                         priv_lvl_i,
  input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0] conf_addr_i,
  input  pmpcfg_t [NR_ENTRIES-1:0]          conf_i,
  input  logic                              cfg_update_i,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic                              allow_o,
  output logic                              hit_o,
  output logic [IdxW-1:0]                   match_idx_o
);

  localparam int unsigned ScanCount =
      ((CVA6Cfg.NrPMPEntries == 8'd0) || (32'(CVA6Cfg.NrPMPEntries) > NR_ENTRIES))
      ? NR_ENTRIES : 32'(CVA6Cfg.NrPMPEntries);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(ScanCount - 1);

  state_e         state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [PLEN-1:0] addr_q, addr_d;
  pmp_access_t    access_q, access_d;
  priv_lvl_t      priv_q, priv_d;
  pmp_seq_rsp_t   rsp_q, rsp_d;

  pmpcfg_t          cur_cfg;
  logic [PMP_LEN-1:0] prev_addr;
  logic             entry_match;
  logic             cache_hit;
  pmp_seq_rsp_t     cached_rsp;
  logic             unused_bits;

  assign cur_cfg   = conf_i[idx_q];
  assign prev_addr = (idx_q == '0) ? '0 : conf_addr_i[idx_q - 1'b1];

  pmp_entry #(
    .PLEN    (PLEN),
    .PMP_LEN (PMP_LEN)
  ) i_pmp_entry (
    .addr_i           (addr_q),
    .conf_addr_i      (conf_addr_i[idx_q]),
    .conf_addr_prev_i (prev_addr),
    .conf_addr_mode_i (cur_cfg.addr_mode),
    .match_o          (entry_match)
  );

`ifdef PMP_SEQ_LAST_HIT_EN
  logic         cache_valid_q;
  logic         cfg_seen_q;
  pmp_seq_tag_t cache_tag_q;
  pmp_seq_rsp_t cache_rsp_q;
  pmp_seq_tag_t req_tag;
  pmp_seq_tag_t cur_tag;
  logic         rsp_done;

  assign req_tag    = '{addr: TAG_ADDR_W'(addr_i[PLEN-1:2]), access: access_i, priv: priv_lvl_i};
  assign cur_tag    = '{addr: TAG_ADDR_W'(addr_q[PLEN-1:2]), access: access_q, priv: priv_q};
  assign cache_hit  = cache_valid_q && !cfg_update_i && (cache_tag_q == req_tag);
  assign cached_rsp = cache_rsp_q;
  assign rsp_done   = (state_q == RESP) && rsp_ready_i;

  // cfg_seen_q tracks a CSR write anywhere in the current request's lifetime
  // (accept cycle included); such a result must not be cached.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cache_valid_q <= 1'b0;
      cfg_seen_q    <= 1'b0;
    end else begin
      if ((state_q == IDLE) && req_valid_i) cfg_seen_q <= cfg_update_i;
      else if (cfg_update_i)                 cfg_seen_q <= 1'b1;

      if (cfg_update_i)                  cache_valid_q <= 1'b0;
      else if (rsp_done && !cfg_seen_q)  cache_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rsp_done && !cfg_seen_q && !cfg_update_i) begin
      cache_tag_q <= cur_tag;
      cache_rsp_q <= rsp_q;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cached_rsp = '0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    access_d = access_q;
    priv_d   = priv_q;
    rsp_d    = rsp_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d   = addr_i;
          access_d = access_i;
          priv_d   = priv_lvl_i;
          idx_d    = '0;
          if (cache_hit) begin
            rsp_d   = cached_rsp;
            state_d = RESP;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        // A CSR write discards this cycle's match and restarts the scan.
        if (cfg_update_i) begin
          idx_d = '0;
        end else if (entry_match) begin
          rsp_d.allow = pmp_allow(cur_cfg, access_q, priv_q, 1'b1);
          rsp_d.hit   = 1'b1;
          rsp_d.idx   = IDX_MAX_W'(idx_q);
          state_d     = RESP;
        end else if (idx_q == LastIdx) begin
          rsp_d.allow = pmp_allow(cur_cfg, access_q, priv_q, 1'b0);
          rsp_d.hit   = 1'b0;
          rsp_d.idx   = '0;
          state_d     = RESP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      addr_q   <= '0;
      access_q <= '0;
      priv_q   <= '0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      access_q <= access_d;
      priv_q   <= priv_d;
      rsp_q    <= rsp_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign allow_o     = rsp_q.allow;
  assign hit_o       = rsp_q.hit;
  assign match_idx_o = rsp_q.idx[IdxW-1:0];
  assign unused_bits = ^{rsp_q.idx, cur_cfg.reserved};

endmodule

// File: tb/tb_pmp_seq_checker.sv
module tb_pmp_seq_checker;
  import pmp_seq_pkg::*;

  localparam int NR = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [55:0] addr;
  pmp_access_t access;
  priv_lvl_t   priv;
  logic [NR-1:0][53:0] conf_addr;
  pmpcfg_t [NR-1:0]    conf;
  logic        cfg_update;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        allow;
  logic        hit;
  logic [3:0]  match_idx;

  int n_vec = 0;
  int n_miscmp = 0;

  // last-hit cache model (only consulted when the feature is built in)
  bit          mc_valid = 0;
  logic [53:0] mc_word;
  logic [2:0]  mc_acc;
  logic [1:0]  mc_priv;

  always #5 clk = ~clk;

  pmp_seq_checker #(
    .PLEN       (56),
    .PMP_LEN    (54),
    .NR_ENTRIES (NR)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .addr_i       (addr),
    .access_i     (access),
    .priv_lvl_i   (priv),
    .conf_addr_i  (conf_addr),
    .conf_i       (conf),
    .cfg_update_i (cfg_update),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .allow_o      (allow),
    .hit_o        (hit),
    .match_idx_o  (match_idx)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit entry_hits(input int i, input logic [55:0] a56);
    longint unsigned a, pa, lo, hi, size, base;
    int t;
    a  = 64'(a56);
    pa = 64'(conf_addr[i]);
    case (conf[i].addr_mode)
      PMP_TOR: begin
        lo = (i == 0) ? 64'd0 : 64'(conf_addr[i-1]) * 4;
        hi = pa * 4;
        return (a >= lo) && (a < hi);
      end
      PMP_NA4: return (a >= pa * 4) && (a < pa * 4 + 4);
      PMP_NAPOT: begin
        t = 0;
        while (t < 54 && pa[t]) t++;
        if (t + 3 >= 56) return 1'b1;
        size = 64'd1 << (t + 3);
        base = (pa * 4) / size * size;
        return (a >= base) && (a < base + size);
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic model(input logic [55:0] a, input logic [2:0] ac, input logic [1:0] pv,
                       output logic e_allow, output logic e_hit, output logic [3:0] e_idx,
                       output int e_lat);
    e_hit = 0; e_idx = 0; e_lat = NR + 1;
    for (int i = 0; i < NR; i++) begin
      if (!e_hit && entry_hits(i, a)) begin
        e_hit = 1; e_idx = 4'(i); e_lat = i + 2;
      end
    end
    if (e_hit) begin
      if (pv == PRIV_LVL_M && !conf[e_idx].locked) e_allow = 1;
      else e_allow = ((conf[e_idx].access & ac) == ac);
    end else begin
      e_allow = (pv == PRIV_LVL_M);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_entry(input int i, input pmp_addr_mode_t m, input logic [2:0] ac,
                           input logic lk, input logic [53:0] pa);
    conf[i].addr_mode = m;
    conf[i].access    = ac;
    conf[i].locked    = lk;
    conf[i].reserved  = 2'b00;
    conf_addr[i]      = pa;
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < NR; i++) set_entry(i, PMP_OFF, 3'b000, 1'b0, 54'd0);
  endtask

  task automatic pulse_update();
    @(negedge clk); cfg_update = 1;
    @(negedge clk); cfg_update = 0;
    mc_valid = 0;
  endtask

  // Called at a negedge with the DUT idle. lat counts cycles from accept.
  task automatic run_req(input logic [55:0] a, input logic [2:0] ac, input logic [1:0] pv,
                         input int stall, output logic ra, output logic rh,
                         output logic [3:0] ri, output int lat);
    addr = a; access = ac; priv = pv; req_valid = 1;
    chk("req_ready_idle", 64'(req_ready), 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_timeout", 64'(rsp_valid), 1);
    ra = allow; rh = hit; ri = match_idx;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 1);
      chk("hold_ready", 64'(req_ready), 0);
      chk("hold_allow", 64'(allow), 64'(ra));
      chk("hold_hit",   64'(hit),   64'(rh));
      chk("hold_idx",   64'(match_idx), 64'(ri));
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("rsp_drop", 64'(rsp_valid), 0);
  endtask

  task automatic do_vec(input string name, input logic [55:0] a, input logic [2:0] ac,
                        input logic [1:0] pv, input logic e_allow, input logic e_hit,
                        input logic [3:0] e_idx, input int e_lat, input int stall);
    logic ra, rh;
    logic [3:0] ri;
    int lat;
    int exp_lat;
    exp_lat = e_lat;
`ifdef PMP_SEQ_LAST_HIT_EN
    if (mc_valid && mc_word == a[55:2] && mc_acc == ac && mc_priv == pv) exp_lat = 1;
    mc_valid = 1; mc_word = a[55:2]; mc_acc = ac; mc_priv = pv;
`endif
    run_req(a, ac, pv, stall, ra, rh, ri, lat);
    chk({name, "_allow"}, 64'(ra), 64'(e_allow));
    chk({name, "_hit"},   64'(rh), 64'(e_hit));
    chk({name, "_idx"},   64'(ri), 64'(e_idx));
    chk({name, "_lat"},   64'(lat), 64'(exp_lat));
  endtask

  task automatic config_a();
    clear_cfg();
    set_entry(1, PMP_TOR,   3'b011, 1'b0, 54'h800);        // [0, 0x2000) RW
    set_entry(2, PMP_NA4,   3'b000, 1'b0, 54'h400);        // 0x1000, no access
    set_entry(3, PMP_NAPOT, 3'b001, 1'b0, 54'h2000_01FF);  // 0x8000_0000 / 4KiB, R
    set_entry(4, PMP_NAPOT, 3'b111, 1'b1, 54'h2400_0000);  // 0x9000_0000 / 8B, RWX locked
    set_entry(6, PMP_NA4,   3'b000, 1'b1, 54'h2800_0000);  // 0xA000_0000 locked, none
    set_entry(7, PMP_NA4,   3'b000, 1'b0, 54'h2C00_0000);  // 0xB000_0000 unlocked, none
  endtask

  typedef struct {
    logic [55:0] addr;
    logic [2:0]  acc;
    logic [1:0]  priv;
    logic        allow;
    logic        hit;
    logic [3:0]  idx;
    int          lat;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic ra, rh, e_allow, e_hit;
    logic [3:0] ri, e_idx;
    logic [55:0] ra_addr;
    logic [2:0]  r_acc;
    logic [1:0]  r_priv;
    int lat, e_lat;

    tbl[0]  = '{56'h8000_0010, 3'b001, 2'b00, 1'b1, 1'b1, 4'd3,  5};
    tbl[1]  = '{56'h8000_0010, 3'b010, 2'b00, 1'b0, 1'b1, 4'd3,  5};
    tbl[2]  = '{56'h0000_1000, 3'b010, 2'b01, 1'b1, 1'b1, 4'd1,  3};
    tbl[3]  = '{56'h0000_1000, 3'b100, 2'b01, 1'b0, 1'b1, 4'd1,  3};
    tbl[4]  = '{56'h0000_1FFC, 3'b011, 2'b00, 1'b1, 1'b1, 4'd1,  3};
    tbl[5]  = '{56'h0000_2000, 3'b001, 2'b00, 1'b0, 1'b0, 4'd0, 17};
    tbl[6]  = '{56'h0000_2000, 3'b001, 2'b11, 1'b1, 1'b0, 4'd0, 17};
    tbl[7]  = '{56'h9000_0004, 3'b100, 2'b00, 1'b1, 1'b1, 4'd4,  6};
    tbl[8]  = '{56'h9000_0008, 3'b001, 2'b01, 1'b0, 1'b0, 4'd0, 17};
    tbl[9]  = '{56'hA000_0000, 3'b001, 2'b11, 1'b0, 1'b1, 4'd6,  8};
    tbl[10] = '{56'hB000_0000, 3'b010, 2'b11, 1'b1, 1'b1, 4'd7,  9};
    tbl[11] = '{56'h8000_0FFC, 3'b001, 2'b01, 1'b1, 1'b1, 4'd3,  5};
    tbl[12] = '{56'h8000_1000, 3'b001, 2'b01, 1'b0, 1'b0, 4'd0, 17};
    tbl[13] = '{56'h0000_0000, 3'b001, 2'b11, 1'b1, 1'b1, 4'd1,  3};
    tbl[14] = '{56'h0000_1002, 3'b001, 2'b00, 1'b1, 1'b1, 4'd1,  3};

    rst_n = 0; req_valid = 0; rsp_ready = 0; cfg_update = 0;
    addr = '0; access = '0; priv = '0;
    clear_cfg();
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(req_ready), 1);
    chk("reset_valid", 64'(rsp_valid), 0);
    chk("reset_outs",  64'({allow, hit, match_idx}), 0);
    rst_n = 1;
    @(negedge clk);

    // Config B: one unrelated TOR region, everything else OFF
    set_entry(0, PMP_TOR, 3'b111, 1'b0, 54'h100);
    pulse_update();

    // Reset in the middle of a scan
    addr = 56'h5000; access = ACCESS_READ; priv = PRIV_LVL_U; req_valid = 1;
    @(posedge clk);
    @(negedge clk); req_valid = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    mc_valid = 0;
    chk("midscan_rst_ready", 64'(req_ready), 1);
    chk("midscan_rst_valid", 64'(rsp_valid), 0);
    chk("midscan_rst_outs",  64'({allow, hit, match_idx}), 0);
    @(negedge clk);
    chk("post_rst_valid", 64'(rsp_valid), 0);

    // No match, full scan
    do_vec("nomatch_u", 56'h5000, ACCESS_READ, PRIV_LVL_U, 1'b0, 1'b0, 4'd0, 17, 0);
    do_vec("nomatch_m", 56'h5000, ACCESS_READ, PRIV_LVL_M, 1'b1, 1'b0, 4'd0, 17, 0);

    // Table-driven vectors on config A; vector 1 also exercises 4 cycles of backpressure
    config_a();
    pulse_update();
    for (int k = 0; k < 15; k++) begin
      do_vec($sformatf("tbl%0d", k), tbl[k].addr, tbl[k].acc, tbl[k].priv,
             tbl[k].allow, tbl[k].hit, tbl[k].idx, tbl[k].lat, (k == 1) ? 4 : 0);
    end

    // Repeat, then invalidate and repeat (cache path when built in)
    do_vec("rep_a", 56'h8000_0010, ACCESS_READ, PRIV_LVL_U, 1'b1, 1'b1, 4'd3, 5, 0);
    do_vec("rep_b", 56'h8000_0010, ACCESS_READ, PRIV_LVL_U, 1'b1, 1'b1, 4'd3, 5, 0);
    pulse_update();
    do_vec("rep_c", 56'h8000_0010, ACCESS_READ, PRIV_LVL_U, 1'b1, 1'b1, 4'd3, 5, 0);

    // Config update at idx 5 restarts the scan with the new config
    clear_cfg();
    set_entry(10, PMP_NA4, 3'b111, 1'b0, 54'h1000);
    pulse_update();
    addr = 56'h4000; access = ACCESS_READ; priv = PRIV_LVL_U; req_valid = 1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 64) begin
      if (lat == 6) begin
        set_entry(2, PMP_NA4, 3'b001, 1'b0, 54'h1000);
        cfg_update = 1;
      end else begin
        cfg_update = 0;
      end
      @(negedge clk);
      lat++;
    end
    cfg_update = 0;
    chk("upd_valid", 64'(rsp_valid), 1);
    chk("upd_idx",   64'(match_idx), 2);
    chk("upd_hit",   64'(hit), 1);
    chk("upd_allow", 64'(allow), 1);
    chk("upd_lat",   64'(lat), 10);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    mc_valid = 0;

    // Randomized traffic against the model
    r_acc = 3'b001; r_priv = 2'b00; ra_addr = '0;
    for (int it = 0; it < 120; it++) begin
      if (it % 15 == 0) begin
        for (int i = 0; i < NR; i++) begin
          logic [53:0] b;
          int t;
          b = 54'($urandom_range(0, 32'h3FFF));
          case ($urandom_range(0, 3))
            0: set_entry(i, PMP_OFF, 3'($urandom_range(0, 7)), 1'($urandom), b);
            1: set_entry(i, PMP_TOR, 3'($urandom_range(0, 7)), 1'($urandom), b);
            2: set_entry(i, PMP_NA4, 3'($urandom_range(0, 7)), 1'($urandom), b);
            default: begin
              t = $urandom_range(0, 6);
              b = (b & ~((54'd1 << (t + 1)) - 1)) | ((54'd1 << t) - 1);
              set_entry(i, PMP_NAPOT, 3'($urandom_range(0, 7)), 1'($urandom), b);
            end
          endcase
        end
        pulse_update();
      end
      if (it == 0 || $urandom_range(0, 7) != 0) begin
        if ($urandom_range(0, 1) == 1) begin
          int j;
          j = $urandom_range(0, NR - 1);
          ra_addr = 56'(64'(conf_addr[j]) * 4 + 64'($urandom_range(0, 15)));
        end else begin
          ra_addr = 56'($urandom_range(0, 32'hFFFF));
        end
        r_acc = 3'($urandom_range(1, 7));
        case ($urandom_range(0, 2))
          0: r_priv = PRIV_LVL_U;
          1: r_priv = PRIV_LVL_S;
          default: r_priv = PRIV_LVL_M;
        endcase
      end
      model(ra_addr, r_acc, r_priv, e_allow, e_hit, e_idx, e_lat);
      do_vec("rnd", ra_addr, r_acc, r_priv, e_allow, e_hit, e_idx, e_lat,
             $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
